ps2_host_tx_sched: RTL and testbench



---
 rtl/ps2_host_pkg.sv | 18 +
 rtl/ps2_rr_arb2.sv | 32 +++
 rtl/ps2_host_tx_sched.sv | 182 ++++++++++++++++++
 tb/tb_ps2_host_tx_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
package ps2_host_pkg;

   typedef enum logic [1:0] {
      IDLE,
      INHIBIT,
      SHIFT,
      ACK
   } tx_state_t;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_NOACK   = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   // About 2 ms at a 15 MHz sys_clk.
   localparam int TIMEOUT_CYCLES_DEFAULT = 30000;

endpackage

// File: rtl/ps2_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves away from the last accepted grant.
module ps2_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant,
   output logic       grant_id,
   output logic       grant_vld
);

   logic ptr;

   always_comb begin
      grant_vld = |req;
      if (ptr == 1'b0) begin
         grant_id = req[0] ? 1'b0 : 1'b1;
      end else begin
         grant_id = req[1] ? 1'b1 : 1'b0;
      end
      grant = grant_vld ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= 1'b0;
      end else if (accept) begin
         ptr <= ~grant_id;
      end
   end

endmodule

// File: rtl/ps2_host_tx_sched.sv
// Host-to-device command scheduler: arbitrates two requesters, runs the
// inhibit/request-to-send phase, shifts the 11-bit frame and reports the ack outcome.
`ifndef T_100_MICROSECONDS
`define T_100_MICROSECONDS 1500
`endif

module ps2_host_tx_sched
   import ps2_host_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
   parameter int INHIBIT_CYCLES = `T_100_MICROSECONDS
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [1:0]  req_valid,
   input  logic [15:0] req_data,
   output logic [1:0]  req_ready,
   input  logic        rx_busy,
   input  logic        ps2_clk_posedge,
   input  logic        ps2_clk_negedge,
   output logic        send_req,
   inout  logic        ps2_data,
   output logic        busy,
   output logic        done,
   output logic        done_id,
   output logic [1:0]  err_code
);

   localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [IW-1:0] INH_END  = IW'(INHIBIT_CYCLES);
   localparam logic [IW-1:0] INH_HALF = IW'(INHIBIT_CYCLES / 2);
   localparam logic [TW-1:0] WD_LAST  = TW'(TIMEOUT_CYCLES - 1);

   tx_state_t     state, state_n;
   logic [IW-1:0] inh_cnt;
   logic [TW-1:0] wd_cnt;
   logic [3:0]    bit_idx;
   logic [7:0]    tx_byte;
   logic [7:0]    grant_byte;
   logic          tx_parity;
   logic          tx_id;
   logic          data_low;
   logic          data_sync_p0, data_sync_p1;
   logic [1:0]    grant;
   logic          grant_id, grant_vld;
   logic          accept;
   logic          finish;
   logic [1:0]    finish_err;
   logic          wd_expired;
   logic [15:0]   frame;
   logic          unused_posedge;

   // The posedge strobe only feeds an external debug tap.
   assign unused_posedge = ps2_clk_posedge;

   ps2_rr_arb2 u_arb (
      .clk       (sys_clk),
      .rst       (sys_rst),
      .req       (req_valid),
      .accept    (accept),
      .grant     (grant),
      .grant_id  (grant_id),
      .grant_vld (grant_vld)
   );

   assign grant_byte = grant_id ? req_data[15:8] : req_data[7:0];
   assign req_ready  = accept ? grant : 2'b00;
   assign send_req   = (state == INHIBIT) && (inh_cnt == '0);
   // Index 9 is the stop bit; indices above it are never reached.
   assign frame      = {6'b111111, 1'b1, tx_parity, tx_byte};
   assign ps2_data   = (data_low && !sys_rst) ? 1'b0 : 1'bz;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n    = state;
      accept     = 1'b0;
      finish     = 1'b0;
      finish_err = ERR_OK;
      wd_expired = (wd_cnt == WD_LAST) && !ps2_clk_negedge;
      case (state)
         IDLE: begin
            if (grant_vld && !rx_busy && !sys_rst) begin
               accept  = 1'b1;
               state_n = INHIBIT;
            end
         end
         INHIBIT: begin
            if (inh_cnt == INH_END) begin
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (wd_expired) begin
               finish     = 1'b1;
               finish_err = ERR_TIMEOUT;
               state_n    = IDLE;
            end else if (ps2_clk_negedge && bit_idx == 4'd9) begin
               state_n = ACK;
            end
         end
         ACK: begin
            if (wd_expired) begin
               finish     = 1'b1;
               finish_err = ERR_TIMEOUT;
               state_n    = IDLE;
            end else if (ps2_clk_negedge) begin
               finish     = 1'b1;
               finish_err = data_sync_p1 ? ERR_NOACK : ERR_OK;
               state_n    = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      data_sync_p0 <= ps2_data;
      data_sync_p1 <= data_sync_p0;
      if (accept) begin
         tx_byte   <= grant_byte;
         tx_parity <= ~^grant_byte;
         tx_id     <= grant_id;
      end
      if (sys_rst) begin
         data_low <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         done_id  <= 1'b0;
         err_code <= ERR_OK;
         inh_cnt  <= '0;
         wd_cnt   <= '0;
         bit_idx  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               inh_cnt <= '0;
               if (accept) begin
                  busy <= 1'b1;
               end
            end
            INHIBIT: begin
               inh_cnt <= inh_cnt + 1'b1;
               bit_idx <= '0;
               wd_cnt  <= '0;
               // Start bit goes low halfway through the inhibit and is held until the first negedge.
               if (inh_cnt + 1'b1 >= INH_HALF) begin
                  data_low <= 1'b1;
               end
            end
            SHIFT, ACK: begin
               if (ps2_clk_negedge) begin
                  wd_cnt <= '0;
                  if (state == SHIFT) begin
                     data_low <= ~frame[bit_idx];
                     bit_idx  <= bit_idx + 1'b1;
                  end
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            default: ;
         endcase
         if (finish) begin
            done     <= 1'b1;
            busy     <= 1'b0;
            done_id  <= tx_id;
            err_code <= finish_err;
            data_low <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_tx_sched.sv
// Directed bench for ps2_host_tx_sched with a small device model and a completion scoreboard.
module tb_ps2_host_tx_sched;

   localparam int INH = 20;
   localparam int TO  = 100;

   typedef struct packed {
      logic       id;
      logic [7:0] data;
      logic [1:0] err;
   } exp_t;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic [1:0]  req_valid = 2'b00;
   logic [15:0] req_data = 16'h0000;
   logic [1:0]  req_ready;
   logic        rx_busy = 1'b0;
   logic        ps2_clk_posedge = 1'b0;
   logic        ps2_clk_negedge = 1'b0;
   logic        send_req;
   wire         ps2_data;
   logic        busy, done, done_id;
   logic [1:0]  err_code;
   logic        dev_low = 1'b0;

   int   vecs = 0;
   int   errs = 0;
   logic rr_ptr = 1'b0;
   exp_t sb[$];

   assign ps2_data = dev_low ? 1'b0 : 1'bz;
   pullup (ps2_data);

   always #5 sys_clk = ~sys_clk;

   ps2_host_tx_sched #(
      .TIMEOUT_CYCLES (TO),
      .INHIBIT_CYCLES (INH)
   ) dut (
      .sys_clk         (sys_clk),
      .sys_rst         (sys_rst),
      .req_valid       (req_valid),
      .req_data        (req_data),
      .req_ready       (req_ready),
      .rx_busy         (rx_busy),
      .ps2_clk_posedge (ps2_clk_posedge),
      .ps2_clk_negedge (ps2_clk_negedge),
      .send_req        (send_req),
      .ps2_data        (ps2_data),
      .busy            (busy),
      .done            (done),
      .done_id         (done_id),
      .err_code        (err_code)
   );

   function automatic logic line_bit();
      return (ps2_data === 1'b0) ? 1'b0 : 1'b1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic strobe_neg();
      ps2_clk_negedge = 1'b1;
      tick(1);
      ps2_clk_negedge = 1'b0;
   endtask

   task automatic issue(input logic [1:0] vmask, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] exp_err);
      logic exp_id;
      int   n;
      exp_t e;
      exp_id    = (vmask == 2'b11) ? rr_ptr : vmask[1];
      req_data  = {d1, d0};
      req_valid = vmask;
      #1;
      n = 0;
      while (req_ready === 2'b00 && n < 20) begin
         tick(1);
         #1;
         n++;
      end
      chk("req_ready", {30'd0, req_ready}, exp_id ? 32'd2 : 32'd1);
      e.id   = exp_id;
      e.data = exp_id ? d1 : d0;
      e.err  = exp_err;
      sb.push_back(e);
      rr_ptr = ~exp_id;
      tick(1);
      req_valid = 2'b00;
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
      chk("send_req_pulse", {31'd0, send_req}, 32'd1);
      tick(1);
      chk("send_req_width", {31'd0, send_req}, 32'd0);
   endtask

   // mode 0: device acks, 1: no ack, 2: device stops after bit 4, 3: reset after bit 1
   task automatic serve(input int mode);
      exp_t       e;
      logic [9:0] bits;
      int         nbits;
      int         n;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      e     = sb[0];
      bits  = {1'b1, ~^e.data, e.data};
      nbits = (mode == 2) ? 5 : (mode == 3) ? 2 : 10;
      for (int i = 1; i <= INH; i++) begin
         if (i == INH / 2 - 1) chk("start_pre", {31'd0, line_bit()}, 32'd1);
         if (i == INH / 2)     chk("start_at", {31'd0, line_bit()}, 32'd0);
         if (i == INH)         chk("start_end", {31'd0, line_bit()}, 32'd0);
         tick(1);
      end
      for (int k = 0; k < nbits; k++) begin
         strobe_neg();
         tick(2);
         chk($sformatf("frame_bit%0d", k), {31'd0, line_bit()}, {31'd0, bits[k]});
      end
      if (mode == 3) begin
         sys_rst = 1'b1;
         #1;
         chk("rst_release_now", {31'd0, line_bit()}, 32'd1);
         tick(1);
         sys_rst = 1'b0;
         chk("rst_line", {31'd0, line_bit()}, 32'd1);
         chk("rst_busy", {31'd0, busy}, 32'd0);
         chk("rst_done", {31'd0, done}, 32'd0);
         void'(sb.pop_front());
         rr_ptr = 1'b0;
         tick(2);
         return;
      end
      if (mode == 2) begin
         n = 2;
         while (done !== 1'b1 && n < TO + 20) begin
            tick(1);
            n++;
         end
         chk("timeout_latency", n, TO);
      end else begin
         if (mode == 0) dev_low = 1'b1;
         tick(4);
         strobe_neg();
      end
      chk("done", {31'd0, done}, 32'd1);
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      e = sb.pop_front();
      chk("done_id", {31'd0, done_id}, {31'd0, e.id});
      chk("err_code", {30'd0, err_code}, {30'd0, e.err});
      dev_low = 1'b0;
      #1;
      chk("line_released", {31'd0, line_bit()}, 32'd1);
      tick(1);
      chk("done_width", {31'd0, done}, 32'd0);
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      tick(2);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      tick(3);
      sys_rst = 1'b0;
      chk("rst_send_req", {31'd0, send_req}, 32'd0);
      chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
      chk("rst_busy0", {31'd0, busy}, 32'd0);
      chk("rst_done0", {31'd0, done}, 32'd0);
      chk("rst_done_id", {31'd0, done_id}, 32'd0);
      chk("rst_err", {30'd0, err_code}, 32'd0);
      chk("rst_line0", {31'd0, line_bit()}, 32'd1);
      tick(2);

      issue(2'b01, 8'hED, 8'h00, 2'b00);
      serve(0);
      issue(2'b10, 8'h00, 8'hF4, 2'b00);
      serve(0);

      issue(2'b11, 8'h11, 8'h22, 2'b00);
      serve(0);
      issue(2'b11, 8'h33, 8'h44, 2'b00);
      serve(0);
      issue(2'b11, 8'h55, 8'h66, 2'b00);
      serve(0);

      issue(2'b01, 8'h55, 8'h00, 2'b01);
      serve(1);

      rx_busy   = 1'b1;
      req_valid = 2'b10;
      tick(5);
      chk("rx_busy_hold_ready", {30'd0, req_ready}, 32'd0);
      chk("rx_busy_hold_busy", {31'd0, busy}, 32'd0);
      rx_busy = 1'b0;
      issue(2'b10, 8'h00, 8'h9A, 2'b00);
      rx_busy = 1'b1;
      serve(0);
      rx_busy = 1'b0;

      issue(2'b01, 8'h3C, 8'h00, 2'b10);
      serve(2);

      issue(2'b01, 8'hA5, 8'h00, 2'b00);
      serve(3);
      issue(2'b10, 8'h00, 8'h12, 2'b00);
      serve(0);
      issue(2'b11, 8'h77, 8'h88, 2'b00);
      serve(0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
